// File: rtl/tetris_audio_pkg.sv
// Shared constants and types for the Tetris audio tone decoder.
// Periods are in clock cycles at the reference clock.
package tetris_audio_pkg;

    localparam logic [31:0] NOTE1_PERIOD = 32'd151745;
    localparam logic [31:0] NOTE2_PERIOD = 32'd202479;
    localparam logic [31:0] NOTE3_PERIOD = 32'd191113;
    localparam logic [31:0] NOTE4_PERIOD = 32'd170262;
    localparam logic [31:0] THUD_PERIOD  = 32'd454545;
    localparam logic [31:0] DING_PERIOD  = 32'd113636;

    localparam logic [31:0] TEMPO_CYCLES = 32'd25_000_000;
    localparam logic [31:0] SFX_CYCLES   = 32'd10_000_000;

    typedef enum logic [2:0] {
        NONE    = 3'd0,
        NOTE1   = 3'd1,
        NOTE2   = 3'd2,
        NOTE3   = 3'd3,
        NOTE4   = 3'd4,
        THUD    = 3'd5,
        DING    = 3'd6,
        UNKNOWN = 3'd7
    } tone_code_t;

    function automatic logic [31:0] expected_period(input tone_code_t code);
        case (code)
            NOTE1:   return NOTE1_PERIOD;
            NOTE2:   return NOTE2_PERIOD;
            NOTE3:   return NOTE3_PERIOD;
            NOTE4:   return NOTE4_PERIOD;
            THUD:    return THUD_PERIOD;
            DING:    return DING_PERIOD;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/tetris_tone_classify.sv
// Combinational period-to-tone classifier; lowest matching code wins.
// PERIOD_SHIFT divides the reference periods for a proportionally slower clock.
module tetris_tone_classify
    import tetris_audio_pkg::*;
#(
    parameter int TOL_SHIFT    = 5,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic [31:0] period,
    output tone_code_t  tone_class
);

    function automatic logic in_window(input logic [31:0] p, input logic [31:0] exp_p);
        logic signed [33:0] diff;
        diff = $signed({2'b00, p}) - $signed({2'b00, exp_p});
        if (diff < 0) diff = -diff;
        return diff <= $signed({2'b00, exp_p >> TOL_SHIFT});
    endfunction

    // Scan from the highest code down so the lowest matching code is left standing.
    always_comb begin
        tone_class = UNKNOWN;
        for (int c = 6; c >= 1; c--) begin
            if (in_window(period, expected_period(tone_code_t'(3'(c))) >> PERIOD_SHIFT))
                tone_class = tone_code_t'(3'(c));
        end
    end

endmodule

// File: rtl/tetris_tone_decoder.sv
// Measures the period and high time of a PWM audio line and locks onto
// one of the known Tetris tones after CONFIRM consistent periods.
module tetris_tone_decoder
    import tetris_audio_pkg::*;
#(
    parameter int TOL_SHIFT    = 5,
    parameter int CONFIRM      = 2,
    parameter int TIMEOUT      = 1_000_000,
    parameter int PERIOD_SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        audio_in,
    output logic [31:0] period_meas,
    output logic [31:0] high_meas,
    output logic        period_valid,
    output logic [2:0]  tone_code,
    output logic        tone_valid,
    output logic        tone_change,
    output logic        duty_err
);

    localparam logic [1:0] ST_SILENT  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_TRACK   = 2'd2;

    localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT);
    localparam logic [31:0] CONFIRM_CNT = 32'(CONFIRM);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v < TIMEOUT_CNT) ? v + 32'd1 : v;
    endfunction

    function automatic logic duty_bad(input logic [31:0] p, input logic [31:0] h);
        logic signed [33:0] dev;
        dev = $signed({2'b00, h}) - $signed({3'b000, p[31:1]});
        if (dev < 0) dev = -dev;
        return dev > $signed({2'b00, p >> TOL_SHIFT});
    endfunction

    logic        sync_p0, sync_p1, level_p2, rise_p2, fall_p2, high_flag;
    logic        high_now;
    logic [31:0] period_cnt, high_cnt, match_cnt, match_nxt;
    logic [1:0]  state, state_nxt;
    tone_code_t  cand, cand_nxt, cls;
    logic [2:0]  code_nxt;
    logic        timeout;

    // Stage p0-p1: synchronizer; stage p2: registered edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            level_p2  <= 1'b0;
            rise_p2   <= 1'b0;
            fall_p2   <= 1'b0;
            high_flag <= 1'b0;
        end else begin
            sync_p0  <= audio_in;
            sync_p1  <= sync_p0;
            level_p2 <= sync_p1;
            rise_p2  <= sync_p1 & ~level_p2;
            fall_p2  <= ~sync_p1 & level_p2;
            if (rise_p2)      high_flag <= 1'b1;
            else if (fall_p2) high_flag <= 1'b0;
        end
    end

    // The rise cycle itself is the first high cycle of the period.
    assign high_now = rise_p2 | (high_flag & ~fall_p2);

    tetris_tone_classify #(
        .TOL_SHIFT   (TOL_SHIFT),
        .PERIOD_SHIFT(PERIOD_SHIFT)
    ) u_classify (
        .period    (period_meas),
        .tone_class(cls)
    );

    // A rising edge coinciding with the timeout is taken as an edge.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        match_nxt = match_cnt;
        code_nxt  = tone_code;
        timeout   = (state != ST_SILENT) && (period_cnt >= TIMEOUT_CNT) && !rise_p2;
        if (timeout) begin
            state_nxt = ST_SILENT;
            cand_nxt  = NONE;
            match_nxt = 32'd0;
            code_nxt  = 3'(NONE);
        end else begin
            case (state)
                ST_SILENT: begin
                    if (rise_p2) state_nxt = ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (period_valid) begin
                        match_nxt = (cls == cand) ? match_cnt + 32'd1 : 32'd1;
                        cand_nxt  = cls;
                        if (match_nxt >= CONFIRM_CNT) begin
                            state_nxt = ST_TRACK;
                            code_nxt  = 3'(cls);
                        end
                    end
                end
                ST_TRACK: begin
                    if (period_valid && (3'(cls) != tone_code)) begin
                        cand_nxt  = cls;
                        match_nxt = 32'd1;
                        if (CONFIRM_CNT <= 32'd1) code_nxt  = 3'(cls);
                        else                      state_nxt = ST_MEASURE;
                    end
                end
                default: state_nxt = ST_SILENT;
            endcase
        end
    end

    // Stage p3: period/high counters and measurement latch
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt   <= 32'd0;
            high_cnt     <= 32'd0;
            period_meas  <= 32'd0;
            high_meas    <= 32'd0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (timeout) begin
                period_cnt <= 32'd0;
                high_cnt   <= 32'd0;
            end else if (rise_p2) begin
                if (state != ST_SILENT) begin
                    period_meas  <= period_cnt;
                    high_meas    <= high_cnt;
                    period_valid <= 1'b1;
                end
                period_cnt <= 32'd1;
                high_cnt   <= 32'd1;
            end else if (state != ST_SILENT) begin
                period_cnt <= sat_inc(period_cnt);
                if (high_now) high_cnt <= sat_inc(high_cnt);
            end
        end
    end

    // Stage p4: classification FSM and tone outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_SILENT;
            cand        <= NONE;
            match_cnt   <= 32'd0;
            tone_code   <= 3'd0;
            tone_valid  <= 1'b0;
            tone_change <= 1'b0;
            duty_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            match_cnt   <= match_nxt;
            tone_code   <= code_nxt;
            tone_valid  <= (code_nxt != 3'(NONE)) && (code_nxt != 3'(UNKNOWN));
            tone_change <= (code_nxt != tone_code);
            if (period_valid && (state == ST_TRACK) && duty_bad(period_meas, high_meas))
                duty_err <= 1'b1;
        end
    end

endmodule

// File: doc/tetris_tone_decoder.md
TETRIS_TONE_DECODER -- requirements
Module: tetris_tone_decoder

Interface
REQ-001 Parameter TOL_SHIFT, default 5: match tolerance is expected_period >> TOL_SHIFT cycles (about 3.1 %).
REQ-002 Parameter CONFIRM, default 2: number of consecutive matching periods needed to lock a tone.
REQ-003 Parameter TIMEOUT, default 1_000_000: cycles without a rising edge before the input is declared silent.
REQ-004 Port clk, input, 1: single clock; all logic on posedge.
REQ-005 Port reset, input, 1: synchronous, active-high.
REQ-006 Port audio_in, input, 1: PWM square wave, asynchronous to clk.
REQ-007 Port period_meas, output, 32: last measured rising-to-rising spacing, in clk cycles.
REQ-008 Port high_meas, output, 32: high time of the last measured period, in clk cycles.
REQ-009 Port period_valid, output, 1: one-cycle pulse when period_meas and high_meas update.
REQ-010 Port tone_code, output, 3: locked tone. 0 none, 1-4 note1-note4, 5 thud, 6 ding, 7 unknown.
REQ-011 Port tone_valid, output, 1: high while a tone is locked (tone_code 1-6).
REQ-012 Port tone_change, output, 1: one-cycle pulse whenever tone_code changes value.
REQ-013 Port duty_err, output, 1: sticky flag for a high time outside period/2 ± tolerance; cleared only by reset.

Function
REQ-014 audio_in SHALL pass through a 2-flop synchronizer, followed by a registered rising/falling edge detector.
REQ-015 A 32-bit period counter and a 32-bit high counter SHALL run between detected rising edges; the high counter SHALL advance only while the synchronized input is high.
REQ-016 On each detected rising edge after the first, the counts SHALL be latched into period_meas and high_meas, with period_valid asserted the next cycle; the counters then restart, so period_meas equals the exact input period.
REQ-017 Classification SHALL match |period_meas − expected| ≤ expected>>TOL_SHIFT against the expected periods:
  - note1 151745, note2 202479, note3 191113, note4 170262
  - thud 454545, ding 113636
  - No match gives class 7.
  - If more than one class matches, the lowest code wins.
REQ-018 The FSM SHALL use three states:
  - SILENT: no rising edge yet. The first rising edge moves to MEASURE.
  - MEASURE: each period_valid compares its class with the candidate class and increments a match counter, or reloads it to 1 on a mismatch. When the counter reaches CONFIRM, go to TRACK and set tone_code to the candidate.
  - TRACK: a period whose class differs from tone_code returns to MEASURE with that class as candidate at count 1; tone_code holds until the new class is confirmed.
REQ-019 A confirmed class 7 SHALL set tone_code=7 with tone_valid=0.
REQ-020 When the period counter reaches TIMEOUT, any state SHALL go to SILENT: tone_code=0, tone_valid=0, counters cleared, tone_change pulsed if tone_code was nonzero.
REQ-021 A rising edge in the same cycle as the timeout SHALL take priority: it is treated as an edge, not a timeout.
REQ-022 The counters SHALL saturate at TIMEOUT, with no wrap-around.
REQ-023 duty_err SHALL set on a period_valid in TRACK whose |high_meas − period_meas/2| > period_meas>>TOL_SHIFT.

Reset
REQ-024 While reset is asserted, the FSM SHALL be in SILENT and all outputs, counters, synchronizer and edge-detector flops SHALL be 0.
REQ-025 Reset mid-measurement SHALL discard the partial period; the first rising edge after reset only arms measurement, with no period_valid.

Structure
REQ-026 A package tetris_audio_pkg SHALL hold:
  - the six period constants;
  - the tempo 25_000_000 and sfx duration 10_000_000;
  - a tone_code enum: NONE, NOTE1-NOTE4, THUD, DING, UNKNOWN.
REQ-027 Classification SHALL live in one combinational sub-module, tetris_tone_classify (period in, class out).

Verification
REQ-028 Scenario: square wave with period 151745, high 75872 -> first period_valid carries period_meas=151745 and high_meas=75872; after the 2nd valid period, tone_code=1, tone_valid=1 and a single tone_change pulse.
REQ-029 Scenario: 113636-cycle tone switched to 454545 mid-stream -> tone_code stays 6 for one thud period, then goes to 5 after the second thud period.
REQ-030 Scenario: hold audio_in low for 1_000_000 cycles while locked -> tone_code=0, tone_valid=0, one tone_change pulse.
REQ-031 Scenario: period 202479 → code 2 and period 191113 → code 3, with no cross-match; period 140000 → code 7, tone_valid=0.
REQ-032 Scenario: period 170262 with high 20000 -> code 4 locks and duty_err sets and stays set.
REQ-033 Scenario: assert reset mid-period -> all outputs 0 next cycle; no period_valid until two rising edges after release.
